// File: rtl/sti_load_arb_if.sv
// Bundle of requester, transmitter and status signals around the load arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface sti_load_arb_if;
    logic        a_req;
    logic [15:0] a_data;
    logic [4:0]  a_cfg;
    logic        a_ack;
    logic        b_req;
    logic [15:0] b_data;
    logic [4:0]  b_cfg;
    logic        b_ack;
    logic        end_req;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        so_valid;
    logic        busy;
    logic        err;
    logic [7:0]  done_cnt;
    logic [2:0]  dbg_state;

    modport slave (
        input  a_req, a_data, a_cfg, b_req, b_data, b_cfg, end_req, so_valid,
        output a_ack, b_ack, load, pi_data, pi_length, pi_fill, pi_msb, pi_low,
               pi_end, busy, err, done_cnt, dbg_state
    );

    modport master (
        output a_req, a_data, a_cfg, b_req, b_data, b_cfg, end_req, so_valid,
        input  a_ack, b_ack, load, pi_data, pi_length, pi_fill, pi_msb, pi_low,
               pi_end, busy, err, done_cnt, dbg_state
    );
endinterface

// File: rtl/sti_load_arb.sv
// Round-robin arbiter feeding two word requesters into a serial transmitter,
// checking each transfer's serial-valid run length against the granted length.
module sti_load_arb #(
    parameter int TIMEOUT = 16
) (
    input logic         clk,
    input logic         reset,
    sti_load_arb_if.slave bus
);
    // Handshake: a requester holds req (with data/cfg stable) until it sees a
    // one-cycle ack; the word is captured onto pi_* on the same edge as the ack.

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_last_b;
    logic          r_a_ack;
    logic          r_b_ack;
    logic          r_load;
    logic          r_pi_end;
    logic          r_err;
    logic [15:0]   r_pi_data;
    logic [4:0]    r_pi_cfg;
    logic [7:0]    r_done_cnt;
    logic [5:0]    r_expected;
    logic [5:0]    r_bit_cnt;
    logic [TW-1:0] r_timer;

    logic w_grant_b;

    // B wins only when A is idle or when A held the previous grant.
    assign w_grant_b = bus.b_req && (!bus.a_req || !r_last_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_b   <= 1'b1;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_load     <= 1'b0;
            r_pi_end   <= 1'b0;
            r_err      <= 1'b0;
            r_pi_data  <= 16'd0;
            r_pi_cfg   <= 5'd0;
            r_done_cnt <= 8'd0;
            r_expected <= 6'd0;
            r_bit_cnt  <= 6'd0;
            r_timer    <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_load  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.a_req || bus.b_req) begin
                        if (w_grant_b) begin
                            r_pi_data <= bus.b_data;
                            r_pi_cfg  <= bus.b_cfg;
                            r_b_ack   <= 1'b1;
                            r_last_b  <= 1'b1;
                        end else begin
                            r_pi_data <= bus.a_data;
                            r_pi_cfg  <= bus.a_cfg;
                            r_a_ack   <= 1'b1;
                            r_last_b  <= 1'b0;
                        end
                        r_state <= S_LOAD;
                    end else if (bus.end_req) begin
                        r_pi_end <= 1'b1;
                        r_state  <= S_END;
                    end
                end
                S_LOAD: begin
                    r_load     <= 1'b1;
                    r_expected <= {({1'b0, r_pi_cfg[4:3]} + 3'd1), 3'b000};
                    r_timer    <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.so_valid) begin
                        r_bit_cnt <= 6'd1;
                        r_state   <= S_SHIFT;
                    end else if (r_timer == TMAX) begin
                        r_err   <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (bus.so_valid) begin
                        if (r_bit_cnt != 6'd63) r_bit_cnt <= r_bit_cnt + 6'd1;
                    end else begin
                        if (r_bit_cnt == r_expected) r_done_cnt <= r_done_cnt + 8'd1;
                        else                         r_err      <= 1'b1;
                        r_state <= S_GAP;
                    end
                end
                S_GAP:   r_state <= S_IDLE;
                S_END:   r_state <= S_END;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.a_ack     = r_a_ack;
    assign bus.b_ack     = r_b_ack;
    assign bus.load      = r_load;
    assign bus.pi_data   = r_pi_data;
    assign bus.pi_length = r_pi_cfg[4:3];
    assign bus.pi_fill   = r_pi_cfg[2];
    assign bus.pi_msb    = r_pi_cfg[1];
    assign bus.pi_low    = r_pi_cfg[0];
    assign bus.pi_end    = r_pi_end;
    assign bus.err       = r_err;
    assign bus.done_cnt  = r_done_cnt;
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_END);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_sti_load_arb.sv
// Randomized and directed bench for sti_load_arb against a transaction-level
// model that predicts every output each cycle.
module tb_sti_load_arb;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    sti_load_arb_if bus();

    sti_load_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_on = 1'b0;
    logic        m_a_ack = 1'b0, m_b_ack = 1'b0, m_load = 1'b0;
    logic        m_pi_end = 1'b0, m_busy = 1'b0, m_err = 1'b0;
    logic [15:0] m_pi_data = 16'd0;
    logic [4:0]  m_cfg = 5'd0;
    logic [7:0]  m_done = 8'd0;
    bit          m_last_b = 1'b1, m_ended = 1'b0;

    task automatic m_tick(output bit ab);
        @(posedge clk);
        m_a_ack = 1'b0;
        m_b_ack = 1'b0;
        m_load  = 1'b0;
        ab = reset;
        if (reset) begin
            m_on = 1'b1; m_pi_end = 1'b0; m_busy = 1'b0; m_err = 1'b0;
            m_pi_data = 16'd0; m_cfg = 5'd0; m_done = 8'd0;
            m_last_b = 1'b1; m_ended = 1'b0;
        end
    endtask

    initial begin : model
        bit ab, got, pick_b;
        int cnt, want;
        forever begin
            m_tick(ab);
            if (ab || m_ended || !m_on) continue;
            if (bus.a_req || bus.b_req) begin
                if (bus.a_req && bus.b_req) pick_b = !m_last_b;
                else                        pick_b = bus.b_req;
                if (pick_b) begin
                    m_pi_data = bus.b_data; m_cfg = bus.b_cfg; m_b_ack = 1'b1;
                end else begin
                    m_pi_data = bus.a_data; m_cfg = bus.a_cfg; m_a_ack = 1'b1;
                end
                m_last_b = pick_b;
                m_busy = 1'b1;
                m_tick(ab);
                if (ab) continue;
                m_load = 1'b1;
                want = 8 * (int'(m_cfg[4:3]) + 1);
                got = 1'b0;
                for (int t = 0; t < TIMEOUT; t++) begin
                    m_tick(ab);
                    if (ab) break;
                    if (bus.so_valid) begin got = 1'b1; break; end
                end
                if (ab) continue;
                if (!got) m_err = 1'b1;
                else begin
                    cnt = 1;
                    forever begin
                        m_tick(ab);
                        if (ab || !bus.so_valid) break;
                        cnt = (cnt < 63) ? cnt + 1 : 63;
                    end
                    if (ab) continue;
                    if (cnt == want) m_done = m_done + 8'd1;
                    else             m_err = 1'b1;
                end
                m_tick(ab);
                if (ab) continue;
                m_busy = 1'b0;
            end else if (bus.end_req) begin
                m_ended = 1'b1;
                m_pi_end = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge clk) begin
        if (m_on) begin
            check("handshake", {29'd0, bus.a_ack, bus.b_ack, bus.load},
                               {29'd0, m_a_ack, m_b_ack, m_load});
            check("pi_bus", {11'd0, bus.pi_data, bus.pi_length, bus.pi_fill, bus.pi_msb, bus.pi_low},
                            {11'd0, m_pi_data, m_cfg});
            check("status", {21'd0, bus.pi_end, bus.busy, bus.err, bus.done_cnt},
                            {21'd0, m_pi_end, m_busy, m_err, m_done});
            check("ack_overlap", {31'd0, bus.a_ack & bus.b_ack}, 32'd0);
            check("ack_repeat", {30'd0, prev_a & bus.a_ack, prev_b & bus.b_ack}, 32'd0);
        end
        prev_a = bus.a_ack;
        prev_b = bus.b_ack;
    end

    // ---------------- driver tasks ----------------
    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.a_ack | bus.b_ack;
            1:       return bus.load;
            2:       return !bus.busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sig(sel)) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: event not seen within %0d cycles", name, limit);
        end
    endtask

    // Called at the negedge of the load cycle.
    task automatic drive_so(input int delay, input int n);
        tick_n(delay);
        if (n > 0) begin
            bus.so_valid = 1'b1;
            tick_n(n);
            bus.so_valid = 1'b0;
        end
    endtask

    task automatic run_xfer(input bit use_b, input logic [15:0] data, input logic [4:0] cfg,
                            input int delay, input int n);
        bit ok;
        if (use_b) begin bus.b_req = 1'b1; bus.b_data = data; bus.b_cfg = cfg; end
        else       begin bus.a_req = 1'b1; bus.a_data = data; bus.a_cfg = cfg; end
        wait_for(0, "ack", 80, ok);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        if (!ok) return;
        wait_for(1, "load", 4, ok);
        if (!ok) return;
        drive_so(delay, n);
        wait_for(2, "idle", TIMEOUT + 10, ok);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_n(1);
        check("rst_handshake", {29'd0, bus.a_ack, bus.b_ack, bus.load}, 32'd0);
        check("rst_pi", {16'd0, bus.pi_data}, 32'd0);
        check("rst_status", {21'd0, bus.pi_end, bus.busy, bus.err, bus.done_cnt}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int len_bits, n, delay;
        logic [4:0] cfg;
        bus.a_req = 0; bus.a_data = 0; bus.a_cfg = 0;
        bus.b_req = 0; bus.b_data = 0; bus.b_cfg = 0;
        bus.end_req = 0; bus.so_valid = 0;
        tick_n(2);
        do_reset();

        // Single A transfer, 16 bits, valid starts 2 cycles after load.
        bus.a_data = 16'hA5C3; bus.a_cfg = 5'b01000; bus.a_req = 1'b1;
        tick_n(1);
        check("038_ack", {31'd0, bus.a_ack}, 32'd1);
        check("038_pi_data", {16'd0, bus.pi_data}, 32'h0000A5C3);
        check("038_pi_length", {30'd0, bus.pi_length}, 32'd1);
        bus.a_req = 1'b0;
        tick_n(1);
        check("038_load", {31'd0, bus.load}, 32'd1);
        drive_so(2, 16);
        tick_n(1);
        check("038_busy_gap", {31'd0, bus.busy}, 32'd1);
        tick_n(1);
        check("038_busy_low", {31'd0, bus.busy}, 32'd0);
        check("038_done", {24'd0, bus.done_cnt}, 32'd1);
        check("038_err", {31'd0, bus.err}, 32'd0);

        // Reset in the middle of a shift run.
        bus.a_cfg = 5'b01000; bus.a_req = 1'b1;
        tick_n(1);
        bus.a_req = 1'b0;
        tick_n(1);
        bus.so_valid = 1'b1;
        tick_n(5);
        do_reset();
        bus.so_valid = 1'b0;
        tick_n(2);
        check("043_done_after", {24'd0, bus.done_cnt}, 32'd0);

        // Timeout: no serial valid after load.
        bus.a_cfg = 5'b00000; bus.a_req = 1'b1;
        tick_n(1);
        bus.a_req = 1'b0;
        tick_n(1);
        check("041_load", {31'd0, bus.load}, 32'd1);
        tick_n(15);
        check("041_err_before", {31'd0, bus.err}, 32'd0);
        tick_n(1);
        check("041_err_at16", {31'd0, bus.err}, 32'd1);
        check("041_busy_gap", {31'd0, bus.busy}, 32'd1);
        tick_n(1);
        check("041_idle", {31'd0, bus.busy}, 32'd0);
        do_reset();

        // Both requesters held: alternating grants starting with A.
        exp_q = {16'h0A0A, 16'h0B0B, 16'h0A0A, 16'h0B0B};
        bus.a_data = 16'h0A0A; bus.b_data = 16'h0B0B;
        bus.a_cfg = 5'd0; bus.b_cfg = 5'd0;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_for(0, "039_ack", 40, ok);
            if (!ok) break;
            check("039_order", {16'd0, bus.pi_data}, {16'd0, exp_q.pop_front()});
            wait_for(1, "039_load", 4, ok);
            drive_so(1, 8);
            wait_for(2, "039_idle", TIMEOUT + 10, ok);
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        tick_n(1);
        check("039_done", {24'd0, bus.done_cnt}, 32'd4);

        // 32-bit grant with only 31 valid bits, then a good transfer.
        run_xfer(1'b0, 16'h1234, 5'b11000, 1, 31);
        check("040_err", {31'd0, bus.err}, 32'd1);
        check("040_done", {24'd0, bus.done_cnt}, 32'd4);
        run_xfer(1'b1, 16'h4321, 5'b00111, 0, 8);
        check("040_next_done", {24'd0, bus.done_cnt}, 32'd5);

        // A request that disappears before being granted.
        bus.a_cfg = 5'd0; bus.a_req = 1'b1;
        tick_n(1);
        bus.a_req = 1'b0;
        tick_n(1);
        tick_n(2);
        bus.b_req = 1'b1;
        tick_n(1);
        bus.b_req = 1'b0;
        bus.so_valid = 1'b1;
        tick_n(8);
        bus.so_valid = 1'b0;
        wait_for(2, "034_idle", TIMEOUT + 10, ok);
        tick_n(3);
        check("034_done", {24'd0, bus.done_cnt}, 32'd6);

        // Randomized traffic, long enough for done_cnt to wrap.
        for (int i = 0; i < 320; i++) begin
            cfg = 5'($urandom_range(0, 31));
            len_bits = 8 * (int'(cfg[4:3]) + 1);
            n = ($urandom_range(0, 99) < 92) ? len_bits : int'($urandom_range(1, 40));
            delay = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 18));
            run_xfer(1'($urandom_range(0, 1)), 16'($urandom), cfg, delay, n);
            tick_n($urandom_range(0, 2));
        end

        // End of stream: absorbing, ignores requests, cleared only by reset.
        do_reset();
        tick_n(1);
        bus.end_req = 1'b1;
        tick_n(1);
        bus.end_req = 1'b0;
        check("042_pi_end", {31'd0, bus.pi_end}, 32'd1);
        check("042_busy", {31'd0, bus.busy}, 32'd0);
        bus.b_data = 16'hBEEF; bus.b_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick_n(1);
            check("042_no_ack", {31'd0, bus.b_ack}, 32'd0);
        end
        check("042_pi_end_held", {31'd0, bus.pi_end}, 32'd1);
        bus.b_req = 1'b0;
        do_reset();
        check("042_pi_end_cleared", {31'd0, bus.pi_end}, 32'd0);
        tick_n(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sti_load_arb.md
STI_LOAD_ARB -- requirements
Module: sti_load_arb

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles to wait for the first so_valid after load.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_req  input  1  requester A has a word pending; held until a_ack.
REQ-005 a_data  input  16  requester A payload.
REQ-006 a_cfg  input  5  requester A {length[1:0], fill, msb, low}.
REQ-007 a_ack  output  1  one-cycle grant pulse to A.
REQ-008 b_req, b_data, b_cfg, b_ack: same widths and meanings as the A ports, for requester B.
REQ-009 end_req  input  1  request to terminate the stream.
REQ-010 load  output  1  one-cycle load strobe to the serial transmitter.
REQ-011 pi_data  output  16  payload to the transmitter.
REQ-012 pi_length  output  2  transmit length: 00=8, 01=16, 10=24, 11=32 bits.
REQ-013 pi_fill, pi_msb, pi_low  output  1 each  transmitter mode bits.
REQ-014 pi_end  output  1  end-of-stream flag to the transmitter.
REQ-015 so_valid  input  1  transmitter serial-valid, monitored for completion.
REQ-016 busy  output  1  high in every state except IDLE and END.
REQ-017 err  output  1  sticky protocol-error flag.
REQ-018 done_cnt  output  8  count of correctly completed transfers.

Function
REQ-019 States SHALL be IDLE, LOAD, WAIT, SHIFT, GAP and END, encoded in 3 bits.
REQ-020 IDLE, any req: grant one requester, register its data and cfg onto pi_* at the same edge, pulse its ack for that cycle, then go to LOAD.
REQ-021 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; after reset, A is preferred.
REQ-022 IDLE, no req, end_req=1: go to END; if req and end_req are high together, the req wins.
REQ-023 LOAD: load=1 for exactly one cycle; expected = 8*(pi_length+1), 6 bits; timer cleared; next state WAIT.
REQ-024 WAIT: timer increments each cycle.
  - so_valid=1: go to SHIFT with bit count = 1.
  - timer reaches TIMEOUT-1 with so_valid=0: set err, go to GAP.
REQ-025 SHIFT: bit count increments on each so_valid=1 cycle; saturate at 63.
REQ-026 SHIFT, on the first cycle with so_valid=0: go to GAP.
  - count == expected: done_cnt increments.
  - count != expected: set err; done_cnt unchanged.
REQ-027 GAP: exactly one cycle with load=0, then IDLE; no grant is issued in GAP.
REQ-028 END: pi_end=1; END is absorbing until reset; no acks are issued; pending reqs are ignored.
REQ-029 pi_data and all pi_* mode bits SHALL hold their values from the last grant until the next grant.
REQ-030 done_cnt SHALL wrap from 255 to 0.
REQ-031 err, once set, SHALL stay set until reset.
REQ-032 A requester's ack SHALL never be high in two consecutive cycles.
REQ-033 At most one ack SHALL be high in any cycle.
REQ-034 A requester that deasserts req before being granted is simply not granted; no error is raised.
REQ-035 load and ack SHALL be registered outputs.

Reset
REQ-036 While reset=1 at a rising edge:
  - state = IDLE; round-robin pointer favours A.
  - load, a_ack, b_ack, pi_end, err, busy = 0.
  - pi_data = 0; pi_length = 00; pi_fill, pi_msb, pi_low = 0; done_cnt = 0.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer: no ack, no done_cnt increment, no err is set.

Verification
REQ-038 a_req=1, a_cfg=5'b01000, a_data=16'hA5C3; model drives so_valid high 16 cycles starting 2 cycles after load -> a_ack and pi_data=A5C3 at grant; load one cycle later; done_cnt=1; err=0; busy low 2 cycles after so_valid falls.
REQ-039 a_req and b_req both held for 4 transfers -> grants in order A, B, A, B; acks never overlap.
REQ-040 Grant with pi_length=11, so_valid high only 31 cycles -> err=1; done_cnt unchanged; the next request is still served.
REQ-041 so_valid held low after load, TIMEOUT=16 -> err=1 on the 16th cycle after load; state returns to IDLE via GAP.
REQ-042 end_req=1 with no reqs -> pi_end=1 from the next cycle; a later b_req gets no b_ack; reset returns pi_end to 0.
REQ-043 reset pulsed during SHIFT -> next cycle all outputs at reset values; done_cnt=0; err=0.
